bitmap_row_reader: RTL and testbench

Read-side engine for the bitmap row memory: fetches a run of consecutive 1536-bit bitmap rows through the memory's registered-address read port and serializes each row into narrow beats on a valid/ready stream. It sits between the memory's read port (`rdaddress`/`q`, one-cycle read latency) and the downstream display/render consumer. Software or the CPU control logic starts a transfer with a start address and row count, and gets a `done` pulse at the end.

---
 rtl/bitmap_row_reader_pkg.sv | 25 ++
 rtl/bitmap_row_reader_if.sv | 36 +++
 rtl/bitmap_row_reader_serializer.sv | 39 +++
 rtl/bitmap_row_reader.sv | 114 +++++++++++
 tb/tb_bitmap_row_reader.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bitmap_row_reader_pkg.sv
// Shared types and constants for the bitmap row read path.
package bitmap_pkg;

    // Geometry of the bitmap row memory and the output stream.
    // ROW_W must be an exact multiple of BEAT_W.
    localparam int ROW_W  = 1536;
    localparam int ADDR_W = 16;
    localparam int BEAT_W = 32;
    localparam int BEATS  = ROW_W / BEAT_W;
    localparam int BIDX_W = $clog2(BEATS);

    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [BIDX_W-1:0] bidx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAPT,
        ST_STREAM,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/bitmap_row_reader_if.sv
// Memory read port plus the outgoing beat stream of the row reader.
interface bitmap_row_reader_if
    import bitmap_pkg::*;
    ();

    addr_t rdaddress;   // registered read address towards the memory
    row_t  q;           // memory data, valid one cycle after rdaddress is clocked
    logic  out_valid;
    logic  out_ready;
    beat_t out_data;
    logic  out_eor;
    logic  out_last;

    // Reader side
    modport master (
        output rdaddress,
        input  q,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_eor,
        output out_last
    );

    // Memory + consumer side
    modport slave (
        input  rdaddress,
        output q,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_eor,
        input  out_last
    );

endinterface

// File: rtl/bitmap_row_reader_serializer.sv
// Holds one captured row and steps through it one beat at a time, LSB first.
module row_serializer
    import bitmap_pkg::*;
    (
    input  logic  clock,
    input  logic  rst_n,
    input  logic  load,      // capture row_i, restart at beat 0
    input  logic  advance,   // current beat was accepted
    input  row_t  row_i,
    output beat_t beat_o,
    output logic  eor_o      // current beat is the last of the row
);

    row_t  row_buf_q;
    bidx_t beat_idx_q;
    beat_t beat_arr [BEATS];

    // Row buffer and beat index; index wraps to 0 after the last beat.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            row_buf_q  <= '0;
            beat_idx_q <= '0;
        end else if (load) begin
            row_buf_q  <= row_i;
            beat_idx_q <= '0;
        end else if (advance) begin
            beat_idx_q <= eor_o ? '0 : beat_idx_q + bidx_t'(1);
        end
    end

    // Slice the row into beat-sized lanes for the output mux.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign beat_arr[gi] = row_buf_q[gi*BEAT_W +: BEAT_W];
    end

    assign beat_o = beat_arr[beat_idx_q];
    assign eor_o  = (beat_idx_q == bidx_t'(BEATS - 1));

endmodule

// File: rtl/bitmap_row_reader.sv
// Fetches a run of consecutive bitmap rows and streams each one out as beats.
module bitmap_row_reader
    import bitmap_pkg::*;
    (
    input  logic  clock,
    input  logic  rst_n,
    input  logic  start,
    input  addr_t start_addr,
    input  addr_t row_count,
    input  logic  abort,
    output logic  busy,
    output logic  done,
    bitmap_row_reader_if.master bus
);

    rd_state_e state_q, state_d;
    addr_t     cur_addr_q, cur_addr_d;
    addr_t     rows_left_q, rows_left_d;
    addr_t     rdaddr_q, rdaddr_d;

    logic      load;
    logic      advance;
    logic      eor;

    row_serializer u_ser (
        .clock   (clock),
        .rst_n   (rst_n),
        .load    (load),
        .advance (advance),
        .row_i   (bus.q),
        .beat_o  (bus.out_data),
        .eor_o   (eor)
    );

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (row_count == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ:  state_d = ST_CAPT;
            ST_CAPT: state_d = ST_STREAM;
            ST_STREAM: begin
                if (bus.out_ready && eor) begin
                    state_d = (rows_left_q != '0) ? ST_REQ : ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // State-decoded outputs and serializer controls.
    always_comb begin
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE) && !abort;
        bus.out_valid = (state_q == ST_STREAM);
        load          = (state_q == ST_CAPT) && !abort;
        advance       = (state_q == ST_STREAM) && bus.out_ready && !abort;
        bus.out_eor   = eor;
        bus.out_last  = eor && (rows_left_q == '0);
    end

    // Address / row-count bookkeeping registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_q  <= '0;
            rows_left_q <= '0;
            rdaddr_q    <= '0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            rows_left_q <= rows_left_d;
            rdaddr_q    <= rdaddr_d;
        end
    end

    // Bookkeeping next values. The read address is loaded on entry to REQ so it
    // is already presented during REQ and simply holds everywhere else.
    always_comb begin
        cur_addr_d  = cur_addr_q;
        rows_left_d = rows_left_q;
        rdaddr_d    = rdaddr_q;
        if ((state_q == ST_IDLE) && start) begin
            cur_addr_d  = start_addr;
            rows_left_d = row_count;
            if (row_count != '0) begin
                rdaddr_d = start_addr;
            end
        end else if (load) begin
            cur_addr_d  = cur_addr_q + addr_t'(1);   // wraps naturally at 2^ADDR_W
            rows_left_d = rows_left_q - addr_t'(1);
        end else if ((state_q == ST_STREAM) && (state_d == ST_REQ)) begin
            rdaddr_d = cur_addr_q;
        end
    end

    assign bus.rdaddress = rdaddr_q;

endmodule

// File: tb/tb_bitmap_row_reader.sv
// Directed bench for bitmap_row_reader with a behavioural row memory.
module tb_bitmap_row_reader;
    import bitmap_pkg::*;

    logic  clock;
    logic  rst_n;
    logic  start;
    addr_t start_addr;
    addr_t row_count;
    logic  abort;
    logic  busy;
    logic  done;
    row_t  mem_row;

    int n_cmp  = 0;
    int n_fail = 0;

    bitmap_row_reader_if bus ();

    bitmap_row_reader dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .row_count  (row_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bus        (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: beat k of row a is {a - 0x0010, k}, so row 0x0010 holds 0..47.
    function automatic logic [31:0] beat_val(input logic [15:0] a, input int k);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = a - 16'h0010;
        lo = k[15:0];
        return {hi, lo};
    endfunction

    // Registered-address memory: q reflects the address sampled at the last edge.
    always @(posedge clock) begin
        for (int k = 0; k < BEATS; k++) begin
            mem_row[k*BEAT_W +: BEAT_W] <= beat_val(bus.rdaddress, k);
        end
    end
    assign bus.q = mem_row;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one transfer and checks every beat, bubble address and the done pulse.
    // abort_at: global beat index at which to abort (-1 none).
    // glitch_at: cycle at which a stray start is pulsed (-1 none).
    task automatic xfer(input logic [15:0] saddr, input int nrows, input bit rnd,
                        input int abort_at, input int glitch_at);
        int          total;
        int          beat;
        int          cyc;
        int          first_v;
        bit          stall;
        bit          rdy;
        logic [31:0] pdata;
        logic        peor;
        logic        plast;
        logic [15:0] ea;
        logic [15:0] rd_before;
        int          k;

        total   = nrows * BEATS;
        beat    = 0;
        cyc     = 0;
        first_v = -1;
        stall   = 1'b0;
        pdata   = '0;
        peor    = 1'b0;
        plast   = 1'b0;
        rd_before = bus.rdaddress;

        start      = 1'b1;
        start_addr = saddr;
        row_count  = 16'(nrows);
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);

        if (nrows == 0) begin
            check("zero_done", done, 1'b1);
            check("zero_valid", bus.out_valid, 1'b0);
            tick();
            check("zero_done_clr", done, 1'b0);
            check("zero_busy_clr", busy, 1'b0);
            check("zero_valid2", bus.out_valid, 1'b0);
            check("zero_rdaddr", bus.rdaddress, rd_before);
            return;
        end

        while ((beat < total) && (cyc < 4000)) begin
            rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (cyc == glitch_at);
            if (start) begin
                start_addr = 16'h1234;
                row_count  = 16'd5;
            end
            ea = saddr + 16'(beat / BEATS);
            k  = beat % BEATS;
            if (bus.out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (stall) begin
                    check("stall_data", bus.out_data, pdata);
                    check("stall_eor", bus.out_eor, peor);
                    check("stall_last", bus.out_last, plast);
                end
                if (beat == abort_at) begin
                    abort         = 1'b1;
                    bus.out_ready = 1'b0;
                    tick();
                    abort = 1'b0;
                    start = 1'b0;
                    check("abort_valid", bus.out_valid, 1'b0);
                    check("abort_busy", busy, 1'b0);
                    check("abort_done", done, 1'b0);
                    tick();
                    check("abort_done2", done, 1'b0);
                    check("abort_busy2", busy, 1'b0);
                    return;
                end
                bus.out_ready = rdy;
                if (rdy) begin
                    check($sformatf("data_b%0d", beat), bus.out_data, beat_val(ea, k));
                    check($sformatf("eor_b%0d", beat), bus.out_eor, (k == BEATS - 1));
                    check($sformatf("last_b%0d", beat), bus.out_last, (beat == total - 1));
                    $display("beat %0d row_addr %04h data %08h eor %0b last %0b",
                             beat, ea, bus.out_data, bus.out_eor, bus.out_last);
                    beat++;
                end
                stall = !rdy;
                pdata = bus.out_data;
                peor  = bus.out_eor;
                plast = bus.out_last;
            end else begin
                if (stall) check("valid_dropped", 1'b0, 1'b1);
                stall         = 1'b0;
                bus.out_ready = rdy;
                check("bubble_rdaddr", bus.rdaddress, ea);
                check("bubble_busy", busy, 1'b1);
            end
            tick();
            cyc++;
        end
        start = 1'b0;

        check("xfer_timeout", 32'(beat), 32'(total));
        check("first_beat_cycle", 32'(first_v), 32'd2);
        if (!rnd) check("xfer_cycles", 32'(cyc), 32'(nrows * (BEATS + 2)));
        check("done_pulse", done, 1'b1);
        check("done_valid", bus.out_valid, 1'b0);
        tick();
        check("done_clr", done, 1'b0);
        check("busy_clr", busy, 1'b0);
        $display("transfer start %04h rows %0d beats %0d cycles %0d", saddr, nrows, beat, cyc);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        start_addr    = '0;
        row_count     = '0;
        abort         = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_data", bus.out_data, 32'h0);
        check("rst_eor", bus.out_eor, 1'b0);
        check("rst_last", bus.out_last, 1'b0);
        check("rst_rdaddr", bus.rdaddress, 16'h0);
        #12;
        rst_n = 1'b1;
        tick();

        // Single row, beats 0..47
        xfer(16'h0010, 1, 1'b0, -1, -1);
        // Three rows across the address wrap, with a stray start mid-transfer
        xfer(16'hFFFE, 3, 1'b0, -1, 60);
        // Random backpressure over two rows
        xfer(16'h0100, 2, 1'b1, -1, -1);
        // Zero-length transfer
        xfer(16'h0500, 0, 1'b0, -1, -1);
        // Abort at beat 20 of row 2 of 4, then a fresh transfer
        xfer(16'h0200, 4, 1'b0, BEATS + 20, -1);
        xfer(16'h0300, 1, 1'b0, -1, -1);

        // Asynchronous reset in the middle of streaming
        bus.out_ready = 1'b0;
        start      = 1'b1;
        start_addr = 16'h0020;
        row_count  = 16'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_valid", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_valid", bus.out_valid, 1'b0);
        check("arst_data", bus.out_data, 32'h0);
        check("arst_eor", bus.out_eor, 1'b0);
        check("arst_last", bus.out_last, 1'b0);
        check("arst_rdaddr", bus.rdaddress, 16'h0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_done", done, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        // Normal operation after reset
        xfer(16'h0010, 1, 1'b0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
